// File: rtl/ps2_kbd_pkg.sv
// Shared constants, translator state type and helpers for the PS/2 keyboard receiver.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_SLASH  = 8'h4A;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_OUTPUT = 2'd2
    } kbd_state_e;

    function automatic int idle_cnt_width(input int freq);
        int w;
        w = $clog2(freq / 32'sd18000 + 32'sd1);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_kbd_ascii_rx_frame.sv
// PS/2 line conditioning and 11-bit frame receiver.
// Parity is checked only when PS2_KBD_PARITY_CHECK_EN is defined.
module ps2_rx_frame
    import ps2_kbd_pkg::*;
#(
    parameter int clk_freq                  = 50_000_000,
    parameter int ps2_debounce_counter_size = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_code_new,
    output logic [7:0] o_code
);
    localparam int DN = ps2_debounce_counter_size;
    localparam int IW = idle_cnt_width(clk_freq);
    localparam logic [DN-1:0] DB_MAX    = {DN{1'b1}};
    localparam logic [DN-1:0] DB_ONE    = DN'(1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(clk_freq / 32'sd18000 - 32'sd1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

    // bit 0 carries the PS/2 clock, bit 1 the PS/2 data
    logic [1:0]    r_sync1, r_sync2, r_db;
    logic [DN-1:0] r_db_cnt [2];
    logic          r_clk_prev, r_busy;
    logic [10:0]   r_shift;
    logic [IW-1:0] r_idle_cnt;
    logic          w_fall, w_frame_ok;

    assign w_fall = r_clk_prev & ~r_db[0];

    always_comb begin
`ifdef PS2_KBD_PARITY_CHECK_EN
        w_frame_ok = !r_shift[0] && r_shift[10] && odd_parity_ok(r_shift[9:1]);
`else
        w_frame_ok = !r_shift[0] && r_shift[10];
`endif
    end

    // Synchronise both lines and accept a new level only after 2^N stable cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_db    <= 2'b11;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= {DN{1'b0}};
        end else begin
            r_sync1 <= {i_ps2_data, i_ps2_clk};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= {DN{1'b0}};
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= {DN{1'b0}};
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_ONE;
                end
            end
        end
    end

    // Shift bits on clock falls; a long-enough high period closes the frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_prev <= 1'b1;
            r_busy     <= 1'b0;
            r_shift    <= 11'h000;
            r_idle_cnt <= {IW{1'b0}};
            o_code_new <= 1'b0;
            o_code     <= 8'h00;
        end else begin
            r_clk_prev <= r_db[0];
            o_code_new <= 1'b0;
            if (w_fall) begin
                r_shift    <= {r_db[1], r_shift[10:1]};
                r_busy     <= 1'b1;
                r_idle_cnt <= {IW{1'b0}};
            end else if (r_busy && r_db[0]) begin
                if (r_idle_cnt == IDLE_LAST) begin
                    r_busy     <= 1'b0;
                    r_idle_cnt <= {IW{1'b0}};
                    r_shift    <= 11'h000;
                    if (w_frame_ok) begin
                        o_code_new <= 1'b1;
                        o_code     <= r_shift[8:1];
                    end
                end else begin
                    r_idle_cnt <= r_idle_cnt + IDLE_ONE;
                end
            end else begin
                r_idle_cnt <= {IW{1'b0}};
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ascii.sv
// PS/2 keyboard to ASCII translator (scan code set 2, US layout).
// Optional parity check via PS2_KBD_PARITY_CHECK_EN (handled in ps2_rx_frame).
module ps2_kbd_ascii
    import ps2_kbd_pkg::*;
#(
    parameter int clk_freq                  = 50_000_000,
    parameter int ps2_debounce_counter_size = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ascii_new,
    output logic [7:0] o_ascii_code
);
    logic       w_code_new;
    logic [7:0] w_code;
    kbd_state_e r_state;
    logic [7:0] r_code;
    logic       r_ext, r_brk, r_shift_on, r_ctrl, r_caps, r_caps_held;
    logic [7:0] w_letter, w_sym_lo, w_sym_hi, w_map_char;
    logic       w_map_hit;

    ps2_rx_frame #(
        .clk_freq                  (clk_freq),
        .ps2_debounce_counter_size (ps2_debounce_counter_size)
    ) u_rx (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_data (i_ps2_data),
        .o_code_new (w_code_new),
        .o_code     (w_code)
    );

    // Key table: letters give their lowercase form, other keys an unshifted/shifted pair.
    always_comb begin
        w_letter = 8'h00;
        w_sym_lo = 8'h00;
        w_sym_hi = 8'h00;
        case (r_code)
            8'h1C: w_letter = 8'h61;  8'h32: w_letter = 8'h62;  8'h21: w_letter = 8'h63;
            8'h23: w_letter = 8'h64;  8'h24: w_letter = 8'h65;  8'h2B: w_letter = 8'h66;
            8'h34: w_letter = 8'h67;  8'h33: w_letter = 8'h68;  8'h43: w_letter = 8'h69;
            8'h3B: w_letter = 8'h6A;  8'h42: w_letter = 8'h6B;  8'h4B: w_letter = 8'h6C;
            8'h3A: w_letter = 8'h6D;  8'h31: w_letter = 8'h6E;  8'h44: w_letter = 8'h6F;
            8'h4D: w_letter = 8'h70;  8'h15: w_letter = 8'h71;  8'h2D: w_letter = 8'h72;
            8'h1B: w_letter = 8'h73;  8'h2C: w_letter = 8'h74;  8'h3C: w_letter = 8'h75;
            8'h2A: w_letter = 8'h76;  8'h1D: w_letter = 8'h77;  8'h22: w_letter = 8'h78;
            8'h35: w_letter = 8'h79;  8'h1A: w_letter = 8'h7A;
            8'h16: {w_sym_lo, w_sym_hi} = {8'h31, 8'h21};
            8'h1E: {w_sym_lo, w_sym_hi} = {8'h32, 8'h40};
            8'h26: {w_sym_lo, w_sym_hi} = {8'h33, 8'h23};
            8'h25: {w_sym_lo, w_sym_hi} = {8'h34, 8'h24};
            8'h2E: {w_sym_lo, w_sym_hi} = {8'h35, 8'h25};
            8'h36: {w_sym_lo, w_sym_hi} = {8'h36, 8'h5E};
            8'h3D: {w_sym_lo, w_sym_hi} = {8'h37, 8'h26};
            8'h3E: {w_sym_lo, w_sym_hi} = {8'h38, 8'h2A};
            8'h46: {w_sym_lo, w_sym_hi} = {8'h39, 8'h28};
            8'h45: {w_sym_lo, w_sym_hi} = {8'h30, 8'h29};
            8'h0E: {w_sym_lo, w_sym_hi} = {8'h60, 8'h7E};
            8'h4E: {w_sym_lo, w_sym_hi} = {8'h2D, 8'h5F};
            8'h55: {w_sym_lo, w_sym_hi} = {8'h3D, 8'h2B};
            8'h54: {w_sym_lo, w_sym_hi} = {8'h5B, 8'h7B};
            8'h5B: {w_sym_lo, w_sym_hi} = {8'h5D, 8'h7D};
            8'h5D: {w_sym_lo, w_sym_hi} = {8'h5C, 8'h7C};
            8'h4C: {w_sym_lo, w_sym_hi} = {8'h3B, 8'h3A};
            8'h52: {w_sym_lo, w_sym_hi} = {8'h27, 8'h22};
            8'h41: {w_sym_lo, w_sym_hi} = {8'h2C, 8'h3C};
            8'h49: {w_sym_lo, w_sym_hi} = {8'h2E, 8'h3E};
            8'h4A: {w_sym_lo, w_sym_hi} = {8'h2F, 8'h3F};
            8'h29: {w_sym_lo, w_sym_hi} = {ASCII_SPACE, ASCII_SPACE};
            8'h5A: {w_sym_lo, w_sym_hi} = {ASCII_CR, ASCII_CR};
            8'h66: {w_sym_lo, w_sym_hi} = {ASCII_BS, ASCII_BS};
            8'h0D: {w_sym_lo, w_sym_hi} = {ASCII_TAB, ASCII_TAB};
            8'h76: {w_sym_lo, w_sym_hi} = {ASCII_ESC, ASCII_ESC};
            default: w_letter = 8'h00;
        endcase
    end

    // Apply modifiers; ctrl wins over case for letters.
    always_comb begin
        w_map_hit  = 1'b0;
        w_map_char = 8'h00;
        if (r_ext) begin
            case (r_code)
                SC_ENTER: begin w_map_hit = 1'b1; w_map_char = ASCII_CR;    end
                SC_SLASH: begin w_map_hit = 1'b1; w_map_char = ASCII_SLASH; end
                default:  w_map_hit = 1'b0;
            endcase
        end else if (w_letter != 8'h00) begin
            w_map_hit = 1'b1;
            if (r_ctrl)                    w_map_char = w_letter - 8'h60;
            else if (r_shift_on ^ r_caps)  w_map_char = w_letter - 8'h20;
            else                           w_map_char = w_letter;
        end else if (w_sym_lo != 8'h00) begin
            w_map_hit  = 1'b1;
            w_map_char = r_shift_on ? w_sym_hi : w_sym_lo;
        end else begin
            w_map_hit = 1'b0;
        end
    end

    // Translator FSM: prefix/modifier tracking and the registered character strobe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_code       <= 8'h00;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_shift_on   <= 1'b0;
            r_ctrl       <= 1'b0;
            r_caps       <= 1'b0;
            r_caps_held  <= 1'b0;
            o_ascii_new  <= 1'b0;
            o_ascii_code <= 8'h00;
        end else begin
            o_ascii_new <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_code_new) begin
                        r_code  <= w_code;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_OUTPUT;
                    if (r_code == SC_EXT) begin
                        r_ext <= 1'b1;
                    end else if (r_code == SC_BREAK) begin
                        r_brk <= 1'b1;
                    end else if (r_brk) begin
                        r_brk <= 1'b0;
                        r_ext <= 1'b0;
                        if (r_code == SC_LSHIFT || r_code == SC_RSHIFT) r_shift_on  <= 1'b0;
                        if (r_code == SC_CTRL)                          r_ctrl      <= 1'b0;
                        if (r_code == SC_CAPS)                          r_caps_held <= 1'b0;
                    end else begin
                        r_ext <= 1'b0;
                        if (!r_ext && (r_code == SC_LSHIFT || r_code == SC_RSHIFT)) begin
                            r_shift_on <= 1'b1;
                        end else if (!r_ext && r_code == SC_CTRL) begin
                            r_ctrl <= 1'b1;
                        end else if (!r_ext && r_code == SC_CAPS) begin
                            if (!r_caps_held) begin
                                r_caps      <= ~r_caps;
                                r_caps_held <= 1'b1;
                            end
                        end else if (w_map_hit) begin
                            o_ascii_new  <= 1'b1;
                            o_ascii_code <= w_map_char;
                        end
                    end
                end
                ST_OUTPUT: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Self-checking bench for ps2_kbd_ascii: directed scenarios plus randomized key sequences
// compared against a table-driven keyboard model.
module tb_ps2_kbd_ascii;

    localparam int CLK_FREQ = 720_000;   // idle timeout of 40 cycles
    localparam int DBN      = 2;         // debounce window of 4 cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ascii_new;
    logic [7:0] ascii_code;

    always #5 clk = ~clk;

    ps2_kbd_ascii #(
        .clk_freq                  (CLK_FREQ),
        .ps2_debounce_counter_size (DBN)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_ascii_new  (ascii_new),
        .o_ascii_code (ascii_code)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_code_cyc = -100;
    int got_q[$];
    int lat_q[$];

    bit m_shift, m_ctrl, m_caps;
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                      8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                      8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                      8'h35, 8'h1A};
    logic [7:0] sym_codes [26] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                   8'h46, 8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D,
                                   8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h29, 8'h5A, 8'h66,
                                   8'h0D, 8'h76};
    logic [7:0] sym_lo [26] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                                8'h39, 8'h30, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C,
                                8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F, 8'h20, 8'h0D, 8'h08,
                                8'h09, 8'h1B};
    logic [7:0] sym_hi [26] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A,
                                8'h28, 8'h29, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C,
                                8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F, 8'h20, 8'h0D, 8'h08,
                                8'h09, 8'h1B};

    // Capture every strobe and its distance from the frame receiver's code strobe.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (dut.u_rx.o_code_new) last_code_cyc = cyc;
        if (ascii_new) begin
            got_q.push_back(int'(ascii_code));
            lat_q.push_back(cyc - last_code_cyc);
        end
    end

    function automatic int model_char(input logic [7:0] c);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c)
                return m_ctrl ? i + 1 : ((m_shift ^ m_caps) ? 65 + i : 97 + i);
        for (int i = 0; i < 26; i++)
            if (sym_codes[i] == c)
                return m_shift ? int'(sym_hi[i]) : int'(sym_lo[i]);
        return -1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
            if (i == glitch) begin
                repeat (8) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (2**DBN - 1) @(negedge clk);
                ps2_clk = 1'b1;
            end
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic frame_chk(input string tag, input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int glitch, input int exp);
        string t;
        t = $sformatf("%s %02h", tag, b);
        send_frame(b, bad_par, bad_stop, glitch, 11);
        repeat (60) @(negedge clk);
        check({t, " count"}, got_q.size(), (exp < 0) ? 0 : 1);
        if (got_q.size() > 0) begin
            check({t, " code"}, got_q[0], exp);
            check({t, " latency"}, lat_q[0], 2);
            check({t, " held"}, int'(ascii_code), exp);
        end
        got_q.delete();
        lat_q.delete();
    endtask

    task automatic mk(input logic [7:0] c, input int exp);
        frame_chk("make", c, 1'b0, 1'b0, -1, exp);
    endtask

    task automatic brk(input logic [7:0] c);
        frame_chk("brkpfx", 8'hF0, 1'b0, 1'b0, -1, -1);
        frame_chk("break", c, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic do_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_n    = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        got_q.delete();
        lat_q.delete();
        m_shift = 1'b0;
        m_ctrl  = 1'b0;
        m_caps  = 1'b0;
    endtask

    initial begin
        logic [7:0] pool[$];
        logic [7:0] c, shift_code;
        int e;
        int par_exp;

        do_reset();
        check("reset ascii_new", int'(ascii_new), 0);
        check("reset ascii_code", int'(ascii_code), 0);

        mk(8'h1C, 8'h61); brk(8'h1C);
        mk(8'h12, -1); mk(8'h1C, 8'h41); brk(8'h1C); brk(8'h12);
        mk(8'h1C, 8'h61); brk(8'h1C);
        mk(8'h58, -1); brk(8'h58);
        mk(8'h16, 8'h31); brk(8'h16);
        mk(8'h12, -1); mk(8'h16, 8'h21); brk(8'h16);
        mk(8'h1C, 8'h61); brk(8'h1C); brk(8'h12);
        mk(8'h1C, 8'h41); brk(8'h1C);
        mk(8'h58, -1); mk(8'h58, -1); brk(8'h58);
        mk(8'h1C, 8'h61); mk(8'h1C, 8'h61); brk(8'h1C);
        mk(8'h14, -1); mk(8'h21, 8'h03); brk(8'h21); brk(8'h14);
        mk(8'hE0, -1); mk(8'h5A, 8'h0D); mk(8'hE0, -1); brk(8'h5A);
        mk(8'hE0, -1); mk(8'h4A, 8'h2F); mk(8'hE0, -1); brk(8'h4A);
        mk(8'hE0, -1); mk(8'h75, -1); mk(8'hE0, -1); brk(8'h75);

`ifdef PS2_KBD_PARITY_CHECK_EN
        par_exp = -1;
`else
        par_exp = 8'h61;
`endif
        frame_chk("badparity", 8'h1C, 1'b1, 1'b0, -1, par_exp); brk(8'h1C);
        frame_chk("badstop", 8'h1C, 1'b0, 1'b1, -1, -1);
        frame_chk("glitch", 8'h1C, 1'b0, 1'b0, 4, 8'h61); brk(8'h1C);

        mk(8'h12, -1);
        send_frame(8'h1C, 1'b0, 1'b0, -1, 5);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("midreset count", got_q.size(), 0);
        mk(8'h29, 8'h20);
        mk(8'h1C, 8'h61); brk(8'h1C);

        do_reset();
        for (int i = 0; i < 26; i++) pool.push_back(letter_codes[i]);
        for (int i = 0; i < 26; i++) pool.push_back(sym_codes[i]);
        pool.push_back(8'h05); pool.push_back(8'h06); pool.push_back(8'h7E);
        shift_code = 8'h12;
        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    if (!m_shift) begin
                        shift_code = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
                        mk(shift_code, -1);
                        m_shift = 1'b1;
                    end else begin
                        brk(shift_code);
                        m_shift = 1'b0;
                    end
                end
                1: begin
                    if (!m_ctrl) begin mk(8'h14, -1); m_ctrl = 1'b1; end
                    else begin brk(8'h14); m_ctrl = 1'b0; end
                end
                2: begin
                    mk(8'h58, -1);
                    if ($urandom_range(0, 1) == 0) mk(8'h58, -1);
                    brk(8'h58);
                    m_caps = ~m_caps;
                end
                default: begin
                    c = pool[$urandom_range(0, pool.size() - 1)];
                    e = model_char(c);
                    mk(c, e);
                    if ($urandom_range(0, 3) == 0) mk(c, e);
                    brk(c);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
